sobel_nms_block: RTL and testbench
==================================

# sobel_nms_block

Non-maximum suppression stage for the Canny edge chain. It sits directly downstream of the Sobel filter and consumes its per-pixel gradient magnitude and quantised direction as a raster-order stream. For each pixel it keeps the magnitude only if it is a local maximum along the gradient direction, and zeroes it otherwise. Results are packed eight pixels per 64-bit word and written to the thinned-edge SRAM.

## Interface
Parameters:
- WIDTH, 512, pixels per line; multiple of 8, at least 8.
- HEIGHT, 512, lines per frame; at least 3.
- BASE_ADDR, 0, SRAM word address of pixel 0.
- LOW_THRESH, 8'd32, low threshold; used only when NMS_THRESH_EN is defined.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- startEn  in  1  frame start; sampled only in IDLE.
- inValid  in  1  magIn/dirIn valid this cycle; there is no backpressure.
- magIn  in  8  gradient magnitude.
- dirIn  in  8  direction; only bits [1:0] are used (0 = 0°, 1 = 45°, 2 = 90°, 3 = 135°).
- we  out  1  SRAM write strobe, one cycle per word.
- write_addr  out  20  SRAM word address.
- data  out  64  packed output; pixel p goes to byte p%8, byte 0 = bits [7:0].
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at end of frame.

## Operation
- States:
  - IDLE → RUN when startEn=1.
  - RUN → FLUSH after the W·H-th accepted input.
  - FLUSH → DONE after W+1 flush pixels.
  - DONE → IDLE after one cycle, with done=1 in that cycle.
- Inputs and counters:
  - Input counter i (linear index r·W+c) advances only on accepted inValid in RUN.
  - inValid is ignored in IDLE, FLUSH and DONE.
  - startEn is ignored outside IDLE.
- Window storage:
  - Two magnitude line buffers of WIDTH entries plus three 3-tap row shift registers form a 3×3 window.
  - A direction delay of W+1 entries supplies the direction of the centre pixel.
- Output indexing:
  - On accepting input i ≥ W+1, emit output pixel p = i−W−1, the centre of the window.
  - The first W+1 accepted inputs emit nothing.
  - FLUSH emits pixels p = W·H−W−1 … W·H−1, one per cycle; all of these are border pixels.
- Border rule: pixels in row 0, row H−1, column 0 or column W−1 output 0.
- Interior comparison by direction:
  - dir 0: compare with left and right neighbours.
  - dir 1: compare with up-right and down-left.
  - dir 2: compare with up and down.
  - dir 3: compare with up-left and down-right.
  - Keep the magnitude if it is ≥ both neighbours (ties keep); otherwise output 0.
  - All comparisons are unsigned 8-bit.
- Packing:
  - Emitted pixels fill a 64-bit register in byte order.
  - When byte 7 is written, the block drives data, write_addr = BASE_ADDR + p/8, and we.
  - Words are written in strictly increasing address order; W·H/8 words per frame.

## Timing
- Reset values: we=0, write_addr=0, data=0, busy=0, done=0; state IDLE; counters, line buffers, window and pack register cleared.
- Reset asserted mid-frame: the partial word is discarded, no further we, and the block returns to IDLE within the same cycle (asynchronous).
- Latency: if the input completing a word is sampled at edge k, we is high for exactly the cycle starting at edge k+2. data and write_addr are stable while we=1 and hold their values afterwards.
- FLUSH produces one pixel per cycle. done rises at the edge after the final word's we cycle.
- Gaps in inValid stall the pipeline without changing any output value.
- Back-to-back frames: startEn may be asserted in the cycle done=1; it is sampled in IDLE on the next edge.

## Configuration
- NMS_THRESH_EN defined: a kept interior pixel whose magnitude is < LOW_THRESH outputs 0. This adds one comparator; latency is unchanged.
- NMS_THRESH_EN undefined: no threshold is applied and LOW_THRESH is unused.

## Test plan
- Reset: hold reset=0 for 3 cycles with random inputs → we=0, busy=0, done=0, data=0, write_addr=0; no write occurs.
- Vertical edge, with WIDTH=16, HEIGHT=8, BASE_ADDR=0x100:
  - Stimulus: columns 0–7 mag 0; column 8 mag 100, dir 0; column 9 mag 50, dir 0; remaining columns mag 0.
  - Required: 16 writes at 0x100–0x10F in order; rows 1–6 have column 8 = 100 and column 9 = 0; rows 0 and 7 are all zero; done pulses once.
- Uniform field, mag 200 and dir 2 everywhere → interior pixels 200 (ties keep), all border pixels 0; the first word (row 0) is 64'h0.
- Same stimulus as the vertical-edge case with inValid toggling 1,0,0,1,… → identical words and addresses; only the we cycle positions shift.
- Reset pulse after 40 accepted pixels, then a fresh full frame → no we from the aborted frame; the new frame matches the vertical-edge golden output.
- With NMS_THRESH_EN defined and LOW_THRESH=60, vertical-edge frame where column 8 has mag 50 and column 9 has mag 30 → every output byte is 0.

Source files
------------

// File: rtl/sobel_nms_block.sv
// Non-maximum suppression stage: thins Sobel magnitudes along the gradient direction and packs
// eight pixels per 64-bit SRAM word. Define NMS_THRESH_EN to zero kept pixels below LOW_THRESH.
module sobel_nms_block #(
    parameter int unsigned WIDTH      = 512,
    parameter int unsigned HEIGHT     = 512,
    parameter logic [19:0] BASE_ADDR  = 20'd0,
    parameter logic [7:0]  LOW_THRESH = 8'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startEn,
    input  logic        inValid,
    input  logic [7:0]  magIn,
    input  logic [7:0]  dirIn,
    output logic        we,
    output logic [19:0] write_addr,
    output logic [63:0] data,
    output logic        busy,
    output logic        done
);
    localparam int unsigned NPIX   = WIDTH * HEIGHT;
    localparam int unsigned NWORDS = NPIX / 8;
    localparam int unsigned PW     = $clog2(NPIX + 1);
    localparam int unsigned XW     = $clog2(WIDTH);
    localparam int unsigned YW     = $clog2(HEIGHT);
    localparam int unsigned FW     = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            in_cnt_q;
    logic [XW-1:0]            in_col_q, out_col_q;
    logic [YW-1:0]            out_row_q;
    logic [FW-1:0]            flush_cnt_q;
    logic [WIDTH-1:0][7:0]    lb1_q, lb2_q;
    logic [WIDTH:0][1:0]      dir_q;
    logic [2:0][7:0]          win_top_q, win_mid_q, win_bot_q;
    logic [1:0]               cdir_q;
    logic                     emit_q, pix_vld_q, we_q;
    logic [7:0]               pix_q;
    logic [2:0]               byte_idx_q;
    logic [55:0]              pack_q;
    logic [19:0]              word_cnt_q, addr_q;
    logic [63:0]              data_q;
    logic                     accept, flush_emit, start, border, keep;
    logic [7:0]               centre, nb_a, nb_b, nms_pix;

`ifdef NMS_THRESH_EN
    logic unused_sig;
    assign unused_sig = ^dirIn[7:2];
`else
    logic unused_sig;
    assign unused_sig = ^{dirIn[7:2], LOW_THRESH};
`endif

    assign start = (state_q == StIdle) && startEn;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        flush_emit = 1'b0;
        unique case (state_q)
            StIdle:  if (startEn) state_d = StRun;
            StRun: begin
                accept = inValid;
                if (inValid && in_cnt_q == PW'(NPIX - 1)) state_d = StFlush;
            end
            StFlush: begin
                flush_emit = (flush_cnt_q != FW'(WIDTH + 1));
                // Leave only once the final word has actually been written.
                if (we_q && word_cnt_q == 20'(NWORDS)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Window after shifting: index 0 = right column, 1 = centre, 2 = left.
    always_comb begin
        centre = win_mid_q[1];
        nb_a   = win_mid_q[2];
        nb_b   = win_mid_q[0];
        unique case (cdir_q)
            2'd0: begin nb_a = win_mid_q[2]; nb_b = win_mid_q[0]; end
            2'd1: begin nb_a = win_top_q[0]; nb_b = win_bot_q[2]; end
            2'd2: begin nb_a = win_top_q[1]; nb_b = win_bot_q[1]; end
            2'd3: begin nb_a = win_top_q[2]; nb_b = win_bot_q[0]; end
            default: ;
        endcase
        keep = (centre >= nb_a) && (centre >= nb_b);
`ifdef NMS_THRESH_EN
        keep = keep && (centre >= LOW_THRESH);
`endif
        border = (out_row_q == '0) || (out_row_q == YW'(HEIGHT - 1)) ||
                 (out_col_q == '0) || (out_col_q == XW'(WIDTH - 1));
        nms_pix = (keep && !border) ? centre : 8'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt_q    <= '0;
            in_col_q    <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            flush_cnt_q <= '0;
            lb1_q       <= '0;
            lb2_q       <= '0;
            dir_q       <= '0;
            win_top_q   <= '0;
            win_mid_q   <= '0;
            win_bot_q   <= '0;
            cdir_q      <= '0;
            emit_q      <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
            byte_idx_q  <= '0;
            pack_q      <= '0;
            word_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            if (start) begin
                in_cnt_q    <= '0;
                in_col_q    <= '0;
                out_col_q   <= '0;
                out_row_q   <= '0;
                flush_cnt_q <= '0;
                byte_idx_q  <= '0;
                pack_q      <= '0;
                word_cnt_q  <= '0;
            end
            if (accept) begin
                lb1_q[in_col_q] <= magIn;
                lb2_q[in_col_q] <= lb1_q[in_col_q];
                win_bot_q       <= {win_bot_q[1:0], magIn};
                win_mid_q       <= {win_mid_q[1:0], lb1_q[in_col_q]};
                win_top_q       <= {win_top_q[1:0], lb2_q[in_col_q]};
                // Oldest entry before the shift is the new centre pixel's direction.
                cdir_q          <= dir_q[WIDTH];
                dir_q           <= {dir_q[WIDTH-1:0], dirIn[1:0]};
                in_cnt_q        <= in_cnt_q + 1'b1;
                in_col_q        <= (in_col_q == XW'(WIDTH - 1)) ? '0 : in_col_q + 1'b1;
            end
            if (flush_emit) flush_cnt_q <= flush_cnt_q + 1'b1;
            emit_q <= (accept && in_cnt_q >= PW'(WIDTH + 1)) || flush_emit;

            pix_vld_q <= emit_q;
            if (emit_q) begin
                pix_q <= nms_pix;
                if (out_col_q == XW'(WIDTH - 1)) begin
                    out_col_q <= '0;
                    out_row_q <= out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end

            we_q <= 1'b0;
            if (pix_vld_q) begin
                byte_idx_q <= byte_idx_q + 3'd1;
                if (byte_idx_q == 3'd7) begin
                    we_q       <= 1'b1;
                    data_q     <= {pix_q, pack_q};
                    addr_q     <= BASE_ADDR + word_cnt_q;
                    word_cnt_q <= word_cnt_q + 20'd1;
                end else begin
                    pack_q[{byte_idx_q, 3'b000} +: 8] <= pix_q;
                end
            end
        end
    end

    assign we         = we_q;
    assign write_addr = addr_q;
    assign data       = data_q;
    assign busy       = (state_q == StRun) || (state_q == StFlush);
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_sobel_nms_block.sv
// Scoreboard bench for sobel_nms_block: a frame-level reference model queues expected words,
// a monitor pops and compares them on every write strobe.
module tb_sobel_nms_block;
    localparam int          W    = 16;
    localparam int          H    = 8;
    localparam int          N    = W * H;
    localparam int          NW   = N / 8;
    localparam logic [19:0] BASE = 20'h100;
    localparam logic [7:0]  LT   = 8'd60;

    logic        clk = 1'b0;
    logic        reset, startEn, inValid;
    logic [7:0]  magIn, dirIn;
    logic        we, busy, done;
    logic [19:0] write_addr;
    logic [63:0] data;

    sobel_nms_block #(
        .WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .LOW_THRESH(LT)
    ) dut (
        .clk(clk), .reset(reset), .startEn(startEn), .inValid(inValid), .magIn(magIn),
        .dirIn(dirIn), .we(we), .write_addr(write_addr), .data(data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] a;
        logic [63:0] d;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [7:0]  mag_a[N];
    logic [1:0]  dir_a[N];
    logic [63:0] gold[NW];
    logic [19:0] last_a;
    logic [63:0] last_d;
    bit          have_last = 0;
    int          last_we_cyc = -10;
    int          done_cnt = 0;
    int          frames = 0;
    int          next_w;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: per-pixel NMS from the whole frame image.
    function automatic logic [7:0] ref_pix(input int r, input int c);
        int dr, dc;
        logic [7:0] ctr, a, b;
        bit kp;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
        case (dir_a[r*W+c])
            2'd0: begin dr = 0;  dc = 1;  end
            2'd1: begin dr = -1; dc = 1;  end
            2'd2: begin dr = -1; dc = 0;  end
            default: begin dr = -1; dc = -1; end
        endcase
        ctr = mag_a[r*W+c];
        a   = mag_a[(r+dr)*W + (c+dc)];
        b   = mag_a[(r-dr)*W + (c-dc)];
        kp  = (ctr >= a) && (ctr >= b);
`ifdef NMS_THRESH_EN
        if (ctr < LT) kp = 0;
`endif
        return kp ? ctr : 8'd0;
    endfunction

    task automatic build_gold();
        for (int w = 0; w < NW; w++) gold[w] = '0;
        for (int p = 0; p < N; p++) gold[p/8][8*(p%8) +: 8] = ref_pix(p / W, p % W);
    endtask

    task automatic set_vedge(input logic [7:0] m8, input logic [7:0] m9);
        for (int p = 0; p < N; p++) begin
            mag_a[p] = (p % W == 8) ? m8 : (p % W == 9) ? m9 : 8'd0;
            dir_a[p] = 2'd0;
        end
        build_gold();
    endtask

    task automatic set_uniform();
        for (int p = 0; p < N; p++) begin
            mag_a[p] = 8'd200;
            dir_a[p] = 2'd2;
        end
        build_gold();
    endtask

    task automatic set_random();
        for (int p = 0; p < N; p++) begin
            mag_a[p] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 4) * 50)
                                                   : 8'($urandom);
            dir_a[p] = 2'($urandom_range(0, 3));
        end
        build_gold();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            have_last = 0;
        end else begin
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("stray_we", {63'd0, we}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {44'd0, write_addr}, {44'd0, e.a});
                    check("data", data, e.d);
                    if (e.c >= 0) check("we_latency", 64'(cyc), 64'(e.c));
                end
                last_a      = write_addr;
                last_d      = data;
                have_last   = 1;
                last_we_cyc = cyc;
            end else if (have_last) begin
                check("addr_hold", {44'd0, write_addr}, {44'd0, last_a});
                check("data_hold", data, last_d);
            end
            if (done) begin
                done_cnt++;
                check("done_after_last_we", 64'(cyc), 64'(last_we_cyc + 1));
                check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    task automatic start_frame();
        startEn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (busy) break;
        end
        startEn = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        next_w = 0;
    endtask

    // mode 0: continuous, 1: valid pattern 1,0,0, 2: random gaps.
    task automatic feed(input int mode, input int n_acc);
        int i = 0;
        int k = 0;
        bit v;
        logic [31:0] r;
        int p;
        while (i < n_acc) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : ($urandom_range(0, 3) != 0);
            r = $urandom;
            inValid = v;
            if (v) begin
                magIn = mag_a[i];
                dirIn = {r[7:2], dir_a[i]};
                p = i - W - 1;
                if (p >= 0 && p % 8 == 7) begin
                    exp_q.push_back('{a: BASE + 20'(p / 8), d: gold[p/8], c: cyc + 3});
                    next_w = p / 8 + 1;
                end
                i++;
            end else begin
                magIn = r[15:8];
                dirIn = r[23:16];
            end
            k++;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        magIn   = 8'($urandom);
    endtask

    task automatic finish_frame();
        for (int w = next_w; w < NW; w++) exp_q.push_back('{a: BASE + 20'(w), d: gold[w], c: -1});
        for (int k = 0; k < 4 * N && !done; k++) begin
            @(posedge clk);
            #1;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        frames++;
    endtask

    task automatic run_frame(input int mode);
        start_frame();
        feed(mode, N);
        finish_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        startEn = 1'b0;
        inValid = 1'b0;
        magIn   = '0;
        dirIn   = '0;
        for (int k = 0; k < 3; k++) begin
            startEn = 1'($urandom);
            inValid = 1'($urandom);
            magIn   = 8'($urandom);
            dirIn   = 8'($urandom);
            @(posedge clk);
            #1;
            check("rst_we", {63'd0, we}, 64'd0);
            check("rst_busy", {63'd0, busy}, 64'd0);
            check("rst_done", {63'd0, done}, 64'd0);
            check("rst_data", data, 64'd0);
            check("rst_addr", {44'd0, write_addr}, 64'd0);
        end
        startEn = 1'b0;
        inValid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {63'd0, busy}, 64'd0);

        set_vedge(8'd100, 8'd50);
        run_frame(0);
        set_uniform();
        run_frame(0);
        set_vedge(8'd100, 8'd50);
        run_frame(1);

        // Abort after 40 accepts: words 0-1 complete before the reset, word 2 must never appear.
        start_frame();
        feed(0, 40);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_we", {63'd0, we}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        run_frame(0);

        for (int f = 0; f < 3; f++) begin
            set_random();
            run_frame(2);
        end
`ifdef NMS_THRESH_EN
        set_vedge(8'd50, 8'd30);
        run_frame(0);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("done_count", 64'(done_cnt), 64'(frames));
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
